// File: rtl/spi_arb_pkg.sv
// Shared types for the SPI flash arbiter: state encoding and master indices.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2,
        GAP  = 2'd3
    } arb_state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    function automatic arb_state_e own_state(input logic idx);
        return (idx == M1) ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/spi_flash_arbiter_if.sv
// Signal bundle between the two SPI masters, the flash pins and the arbiter.
interface spi_flash_arbiter_if;
    import spi_arb_pkg::*;

    // mN_req asks for the bus; mN_gnt says mN owns it. A grant is only taken back
    // after the owner has both dropped req and returned csn high in one cycle.
    logic m0_req, m0_sck, m0_mosi, m0_csn, m0_gnt, m0_miso;
    logic m1_req, m1_sck, m1_mosi, m1_csn, m1_gnt, m1_miso;
    logic flash_miso, flash_sck, flash_mosi, flash_csn;
    logic busy, viol;
    arb_state_e state_dbg;

    modport slave (
        input  m0_req, m0_sck, m0_mosi, m0_csn,
        input  m1_req, m1_sck, m1_mosi, m1_csn,
        input  flash_miso,
        output m0_gnt, m0_miso, m1_gnt, m1_miso,
        output flash_sck, flash_mosi, flash_csn,
        output busy, viol, state_dbg
    );

    modport master (
        output m0_req, m0_sck, m0_mosi, m0_csn,
        output m1_req, m1_sck, m1_mosi, m1_csn,
        output flash_miso,
        input  m0_gnt, m0_miso, m1_gnt, m1_miso,
        input  flash_sck, flash_mosi, flash_csn,
        input  busy, viol, state_dbg
    );

endinterface

// File: rtl/spi_arb_gap_timer.sv
// Loadable down-counter that saturates at zero; times the CS-high gap between owners.
module spi_arb_gap_timer #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/spi_flash_arbiter.sv
// Two-master SPI flash arbiter: grants at transaction boundaries, round-robin on
// contention, and forces an idle bus gap between owners.
module spi_flash_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned FIRST_PRIO = 0
) (
    input logic          clk_48mhz,
    input logic          reset,
    spi_flash_arbiter_if.slave bus
);

    localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
    localparam logic PRIO_RST = (FIRST_PRIO != 0);

    arb_state_e state_q, state_d;
    logic       ptr_q, ptr_d;
    logic       viol_q, viol_d;
    logic       gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic       sck_q, sck_d, mosi_q, mosi_d, csn_q, csn_d;
    logic       gap_load, gap_dec, gap_zero;

    spi_arb_gap_timer #(.W(GAP_W)) u_gap_timer (
        .clk      (clk_48mhz),
        .rst      (reset),
        .load     (gap_load),
        .load_val (GAP_LOAD),
        .dec      (gap_dec),
        .zero     (gap_zero)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        viol_d   = viol_q;
        gap_load = 1'b0;
        gap_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.m0_req && bus.m1_req) begin
                    state_d = own_state(ptr_q);
                    ptr_d   = ~ptr_q;
                end else if (bus.m0_req) begin
                    state_d = own_state(M0);
                end else if (bus.m1_req) begin
                    state_d = own_state(M1);
                end
            end
            OWN0: begin
                // Dropping req with csn still low is flagged but never cuts the transfer.
                if (!bus.m0_req) begin
                    if (bus.m0_csn) begin
                        state_d  = (GAP_CYCLES > 0) ? GAP : IDLE;
                        gap_load = (GAP_CYCLES > 0);
                    end else begin
                        viol_d = 1'b1;
                    end
                end
            end
            OWN1: begin
                if (!bus.m1_req) begin
                    if (bus.m1_csn) begin
                        state_d  = (GAP_CYCLES > 0) ? GAP : IDLE;
                        gap_load = (GAP_CYCLES > 0);
                    end else begin
                        viol_d = 1'b1;
                    end
                end
            end
            GAP: begin
                gap_dec = 1'b1;
                if (gap_zero) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Flash pins follow the current owner one cycle late; idle bus otherwise.
    always_comb begin
        sck_d  = 1'b0;
        mosi_d = 1'b0;
        csn_d  = 1'b1;
        if (state_q == OWN0) begin
            sck_d  = bus.m0_sck;
            mosi_d = bus.m0_mosi;
            csn_d  = bus.m0_csn;
        end else if (state_q == OWN1) begin
            sck_d  = bus.m1_sck;
            mosi_d = bus.m1_mosi;
            csn_d  = bus.m1_csn;
        end
        gnt0_d = (state_d == OWN0);
        gnt1_d = (state_d == OWN1);
    end

    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= PRIO_RST;
            viol_q  <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            csn_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            viol_q  <= viol_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            csn_q   <= csn_d;
        end
    end

    assign bus.m0_gnt     = gnt0_q;
    assign bus.m1_gnt     = gnt1_q;
    assign bus.m0_miso    = gnt0_q & bus.flash_miso;
    assign bus.m1_miso    = gnt1_q & bus.flash_miso;
    assign bus.flash_sck  = sck_q;
    assign bus.flash_mosi = mosi_q;
    assign bus.flash_csn  = csn_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.viol       = viol_q;
    assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Directed bench for spi_flash_arbiter: one instance with a 4-cycle gap, one with no gap.
module tb_spi_flash_arbiter;
  import spi_arb_pkg::*;

  logic clk_48mhz = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;

  always #10 clk_48mhz = ~clk_48mhz;

  spi_flash_arbiter_if a();
  spi_flash_arbiter_if z();

  spi_flash_arbiter #(.GAP_CYCLES(4), .FIRST_PRIO(0)) dut (
    .clk_48mhz (clk_48mhz),
    .reset     (reset),
    .bus       (a.slave)
  );

  spi_flash_arbiter #(.GAP_CYCLES(0), .FIRST_PRIO(0)) dut_z (
    .clk_48mhz (clk_48mhz),
    .reset     (reset),
    .bus       (z.slave)
  );

  task automatic cyc();
    @(posedge clk_48mhz);
    #1;
  endtask

  task automatic idle_pins();
    a.m0_req = 0; a.m0_sck = 0; a.m0_mosi = 0; a.m0_csn = 1;
    a.m1_req = 0; a.m1_sck = 0; a.m1_mosi = 0; a.m1_csn = 1;
    a.flash_miso = 0;
    z.m0_req = 0; z.m0_sck = 0; z.m0_mosi = 0; z.m0_csn = 1;
    z.m1_req = 0; z.m1_sck = 0; z.m1_mosi = 0; z.m1_csn = 1;
    z.flash_miso = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_pins();
    repeat (3) cyc();
    checks++; if ({a.m0_gnt, a.m1_gnt, a.busy, a.viol} !== 4'b0000) begin failures++;
      $display("FAIL reset_flags: gnt0,gnt1,busy,viol=%b%b%b%b expected 0000", a.m0_gnt, a.m1_gnt, a.busy, a.viol); end
    checks++; if ({a.flash_csn, a.flash_sck, a.flash_mosi} !== 3'b100) begin failures++;
      $display("FAIL reset_bus: csn,sck,mosi=%b%b%b expected 100", a.flash_csn, a.flash_sck, a.flash_mosi); end
    checks++; if (a.state_dbg !== IDLE || z.state_dbg !== IDLE || z.flash_csn !== 1'b1) begin failures++;
      $display("FAIL reset_state: a=%0d z=%0d z_csn=%b expected IDLE IDLE 1", a.state_dbg, z.state_dbg, z.flash_csn); end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_single_owner();
    logic [7:0] pat;
    logic csn_v, sck_v, mosi_v;
    pat = 8'h3C;
    a.m0_req = 1;
    cyc();
    checks++; if ({a.m0_gnt, a.m1_gnt, a.busy} !== 3'b101 || a.state_dbg !== OWN0) begin failures++;
      $display("FAIL single_grant: gnt0,gnt1,busy=%b%b%b state=%0d expected 101 OWN0", a.m0_gnt, a.m1_gnt, a.busy, a.state_dbg); end
    for (int i = 0; i < 12; i++) begin
      csn_v  = (i == 0) || (i >= 10);
      sck_v  = !csn_v && i[0];
      mosi_v = !csn_v && pat[i % 8];
      a.m0_csn = csn_v; a.m0_sck = sck_v; a.m0_mosi = mosi_v;
      a.m1_sck = 1'($urandom_range(0, 1));
      a.m1_mosi = 1'($urandom_range(0, 1));
      a.m1_csn = 1'($urandom_range(0, 1));
      cyc();
      checks++; if ({a.flash_csn, a.flash_sck, a.flash_mosi} !== {csn_v, sck_v, mosi_v}) begin failures++;
        $display("FAIL single_follow[%0d]: csn,sck,mosi=%b%b%b expected %b%b%b", i,
                 a.flash_csn, a.flash_sck, a.flash_mosi, csn_v, sck_v, mosi_v); end
    end
    a.m1_sck = 0; a.m1_mosi = 0; a.m1_csn = 1;
    a.m0_req = 0;
    cyc();
    checks++; if (a.m0_gnt !== 1'b0 || a.state_dbg !== GAP || a.flash_csn !== 1'b1) begin failures++;
      $display("FAIL single_release: gnt0=%b state=%0d csn=%b expected 0 GAP 1", a.m0_gnt, a.state_dbg, a.flash_csn); end
    for (int k = 0; k < 20 && a.busy; k++) cyc();
    checks++; if (a.busy !== 1'b0) begin failures++;
      $display("FAIL single_idle: busy=%b expected 0", a.busy); end
  endtask

  task automatic test_contention();
    a.m0_req = 1; a.m1_req = 1;
    cyc();
    checks++; if ({a.m0_gnt, a.m1_gnt} !== 2'b10) begin failures++;
      $display("FAIL cont_first: gnt0,gnt1=%b%b expected 10", a.m0_gnt, a.m1_gnt); end
    a.m0_csn = 0;
    repeat (3) cyc();
    a.m0_csn = 1; a.m0_req = 0;
    cyc();
    for (int g = 1; g <= 4; g++) begin
      checks++; if (a.state_dbg !== GAP || a.flash_csn !== 1'b1 || {a.m0_gnt, a.m1_gnt} !== 2'b00) begin failures++;
        $display("FAIL cont_gap[%0d]: state=%0d csn=%b gnt=%b%b expected GAP 1 00", g, a.state_dbg, a.flash_csn, a.m0_gnt, a.m1_gnt); end
      cyc();
    end
    checks++; if (a.state_dbg !== IDLE || a.m1_gnt !== 1'b0 || a.flash_csn !== 1'b1) begin failures++;
      $display("FAIL cont_idle: state=%0d gnt1=%b csn=%b expected IDLE 0 1", a.state_dbg, a.m1_gnt, a.flash_csn); end
    cyc();
    checks++; if ({a.m0_gnt, a.m1_gnt} !== 2'b01) begin failures++;
      $display("FAIL cont_handover: gnt0,gnt1=%b%b expected 01", a.m0_gnt, a.m1_gnt); end
    a.m1_req = 0;
    cyc();
    for (int k = 0; k < 20 && a.busy; k++) cyc();
    a.m0_req = 1; a.m1_req = 1;
    cyc();
    checks++; if ({a.m0_gnt, a.m1_gnt} !== 2'b01) begin failures++;
      $display("FAIL cont_second: gnt0,gnt1=%b%b expected 01", a.m0_gnt, a.m1_gnt); end
    a.m1_req = 0;
    cyc();
    for (int k = 0; k < 20 && !a.m0_gnt; k++) cyc();
    checks++; if ({a.m0_gnt, a.m1_gnt} !== 2'b10) begin failures++;
      $display("FAIL cont_back: gnt0,gnt1=%b%b expected 10", a.m0_gnt, a.m1_gnt); end
    a.m0_req = 0;
    cyc();
    for (int k = 0; k < 20 && a.busy; k++) cyc();
    checks++; if (a.busy !== 1'b0) begin failures++;
      $display("FAIL cont_idle_end: busy=%b expected 0", a.busy); end
  endtask

  task automatic test_miso();
    logic [7:0] pat;
    logic [7:0] rx;
    pat = 8'hA5;
    rx = 8'h00;
    a.flash_miso = 1;
    #1;
    checks++; if ({a.m0_miso, a.m1_miso} !== 2'b00) begin failures++;
      $display("FAIL miso_ungranted: m0,m1=%b%b expected 00", a.m0_miso, a.m1_miso); end
    a.m1_req = 1;
    cyc();
    a.m1_csn = 0;
    for (int i = 7; i >= 0; i--) begin
      a.flash_miso = pat[i];
      #1;
      rx = {rx[6:0], a.m1_miso};
      checks++; if (a.m1_miso !== pat[i] || a.m0_miso !== 1'b0) begin failures++;
        $display("FAIL miso_bit[%0d]: m1=%b m0=%b expected %b 0", i, a.m1_miso, a.m0_miso, pat[i]); end
      cyc();
    end
    checks++; if (rx !== 8'hA5) begin failures++;
      $display("FAIL miso_byte: got %h expected a5", rx); end
    a.m1_csn = 1; a.m1_req = 0; a.flash_miso = 0;
    cyc();
    for (int k = 0; k < 20 && a.busy; k++) cyc();
  endtask

  task automatic test_viol();
    a.m0_req = 1;
    cyc();
    a.m0_csn = 0;
    cyc();
    a.m0_req = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++; if (a.m0_gnt !== 1'b1 || a.viol !== 1'b1) begin failures++;
        $display("FAIL viol_hold[%0d]: gnt0=%b viol=%b expected 1 1", i, a.m0_gnt, a.viol); end
    end
    a.m0_csn = 1;
    cyc();
    checks++; if (a.m0_gnt !== 1'b0 || a.viol !== 1'b1) begin failures++;
      $display("FAIL viol_release: gnt0=%b viol=%b expected 0 1", a.m0_gnt, a.viol); end
    for (int k = 0; k < 20 && a.busy; k++) cyc();
    checks++; if (a.viol !== 1'b1 || a.busy !== 1'b0) begin failures++;
      $display("FAIL viol_sticky: viol=%b busy=%b expected 1 0", a.viol, a.busy); end
  endtask

  task automatic test_gap0();
    z.m0_req = 1;
    cyc();
    checks++; if (z.m0_gnt !== 1'b1) begin failures++;
      $display("FAIL gap0_grant: gnt0=%b expected 1", z.m0_gnt); end
    z.m0_csn = 0;
    repeat (2) cyc();
    checks++; if (z.flash_csn !== 1'b0) begin failures++;
      $display("FAIL gap0_csn_low: csn=%b expected 0", z.flash_csn); end
    z.m1_req = 1; z.m0_req = 0; z.m0_csn = 1;
    cyc();
    checks++; if ({z.m0_gnt, z.m1_gnt} !== 2'b00 || z.state_dbg !== IDLE || z.flash_csn !== 1'b1) begin failures++;
      $display("FAIL gap0_idle: gnt=%b%b state=%0d csn=%b expected 00 IDLE 1", z.m0_gnt, z.m1_gnt, z.state_dbg, z.flash_csn); end
    cyc();
    checks++; if (z.m1_gnt !== 1'b1 || z.flash_csn !== 1'b1) begin failures++;
      $display("FAIL gap0_grant1: gnt1=%b csn=%b expected 1 1", z.m1_gnt, z.flash_csn); end
    cyc();
    checks++; if (z.flash_csn !== 1'b1) begin failures++;
      $display("FAIL gap0_csn_after: csn=%b expected 1", z.flash_csn); end
    z.m1_req = 0;
    cyc();
    checks++; if (z.busy !== 1'b0) begin failures++;
      $display("FAIL gap0_end: busy=%b expected 0", z.busy); end
  endtask

  task automatic test_reset_mid();
    a.m0_req = 1;
    cyc();
    a.m0_csn = 0; a.m0_sck = 1;
    cyc();
    checks++; if (a.flash_csn !== 1'b0 || a.flash_sck !== 1'b1 || a.viol !== 1'b1) begin failures++;
      $display("FAIL rmid_pre: csn=%b sck=%b viol=%b expected 0 1 1", a.flash_csn, a.flash_sck, a.viol); end
    #3;
    reset = 1'b1;
    #1;
    checks++; if ({a.flash_csn, a.flash_sck, a.m0_gnt, a.m1_gnt, a.viol, a.busy} !== 6'b100000) begin failures++;
      $display("FAIL rmid_async: csn,sck,g0,g1,viol,busy=%b%b%b%b%b%b expected 100000",
               a.flash_csn, a.flash_sck, a.m0_gnt, a.m1_gnt, a.viol, a.busy); end
    repeat (2) cyc();
    reset = 1'b0;
    a.m0_req = 0; a.m0_csn = 1; a.m0_sck = 0; a.m1_req = 1;
    cyc();
    checks++; if ({a.m0_gnt, a.m1_gnt} !== 2'b01) begin failures++;
      $display("FAIL rmid_m1: gnt0,gnt1=%b%b expected 01", a.m0_gnt, a.m1_gnt); end
    a.m1_req = 0;
    cyc();
    for (int k = 0; k < 20 && a.busy; k++) cyc();
  endtask

  initial begin
    test_reset();
    test_single_owner();
    test_contention();
    test_miso();
    test_viol();
    test_gap0();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_flash_arbiter.md
Name: spi_flash_arbiter

Overview:
- Shares the single SPI configuration-flash port between two SPI masters.
  - Master 0: the bootloader SPI engine.
  - Master 1: a user or ESP32 passthrough engine.
- Grants ownership only at transaction boundaries (owner CS inactive), round-robin on contention.
- Inserts a guaranteed CS-high gap between owners.
- Sits between the masters and the flash pins. Its flash_sck and flash_csn outputs feed the vendor user-clock primitive and the flash chip-select pin.

Parameters:
- GAP_CYCLES, 4, clk_48mhz cycles of forced idle bus (csn=1, sck=0, mosi=0) between two owners; 0 allowed.
- FIRST_PRIO, 0, master given priority on the first contention after reset (0 or 1).

Ports:
- clk_48mhz  in   1  system clock, 48 MHz
- reset      in   1  asynchronous, active-high reset
- m0_req     in   1  master 0 requests the flash bus
- m0_sck     in   1  master 0 SPI clock
- m0_mosi    in   1  master 0 serial data out
- m0_csn     in   1  master 0 chip select, active-low
- m0_gnt     out  1  master 0 owns the bus
- m0_miso    out  1  flash_miso to master 0 while granted, else 0
- m1_req, m1_sck, m1_mosi, m1_csn, m1_gnt, m1_miso  same as master 0, for master 1
- flash_miso in   1  flash serial data in
- flash_sck  out  1  flash clock (registered)
- flash_mosi out  1  flash data (registered)
- flash_csn  out  1  flash chip select (registered)
- busy       out  1  1 in any state other than IDLE
- viol       out  1  sticky; set when an owner drops req while its csn=0; cleared only by reset

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, m0_gnt=m1_gnt=0, flash_csn=1, flash_sck=0, flash_mosi=0, busy=0, viol=0.
  - Priority pointer = FIRST_PRIO; gap counter=0.
- States: IDLE, OWN0, OWN1, GAP.
- IDLE:
  - Only one req high → go to that master's OWN state next cycle.
  - Both high → grant the master the pointer selects; pointer then flips to the other master.
  - Neither high → stay in IDLE.
- OWNn:
  - mn_gnt=1 (registered, asserted the cycle the state is entered).
  - Bus outputs are the registered copy of mn_sck/mn_mosi/mn_csn: 1-cycle latency from master pin to flash pin.
  - mn_miso = flash_miso, combinational, no extra delay.
- Release from OWNn: when mn_req=0 AND mn_csn=1 in the same cycle.
  - GAP_CYCLES>0 → go to GAP.
  - GAP_CYCLES=0 → go to IDLE.
  - mn_gnt drops the next cycle.
- Protocol violation: mn_req=0 while mn_csn=0 keeps ownership until csn=1 and sets viol. The grant is never revoked mid-transaction.
- GAP:
  - Both gnt=0; bus forced idle.
  - Counter loads GAP_CYCLES-1 on entry and decrements; leave to IDLE when counter==0.
  - Counter width is clog2(GAP_CYCLES+1); it never wraps.
  - Requests arriving during GAP are evaluated in IDLE. GAP + IDLE gives handover latency of GAP_CYCLES+1 cycles from release to the next gnt.
- Non-owner and outside-OWN signals:
  - A non-owner's sck/mosi/csn are ignored entirely.
  - A non-owner's miso is 0.
  - Outside OWN states the bus is held idle.
- Same master re-requesting after release: it still passes through GAP. The pointer changes only on contention.
- A master holding req continuously keeps the bus indefinitely; there is no preemption.

Decomposition:
- Shared package spi_arb_pkg:
  - State encoding enum (IDLE, OWN0, OWN1, GAP).
  - Master-index constants M0=0, M1=1.
- One sub-module, spi_arb_gap_timer: loadable down-counter with a zero flag, used for GAP.
- Bus muxing and output registers stay in the top module.

Test Plan:
- Reset, then m0_req=1, m0_csn toggles 1→0→1 with sck bursts → m0_gnt=1 after 1 cycle; flash_csn/sck follow m0 with 1-cycle lag; m1 pins have no effect on the bus.
- m0_req and m1_req rise in the same cycle after reset (FIRST_PRIO=0) → OWN0. After m0 releases: exactly 4 cycles with flash_csn=1, then 1 IDLE cycle, then m1_gnt=1. Next simultaneous contention → m1 is granted first.
- m0 drops req while m0_csn=0 for 10 cycles → m0_gnt stays 1 and viol=1. Grant drops 1 cycle after m0_csn=1. viol stays 1 until reset.
- GAP_CYCLES=0 build, m0 releases with m1_req high → m1_gnt asserted 2 cycles after the release cycle; flash_csn never 0 during handover.
- reset asserted mid-transfer while flash_csn=0 → flash_csn=1, flash_sck=0, gnt=0 immediately without a clock edge. After release, m1_req alone → m1 granted.
- m1 owns, flash_miso driven with pattern 0xA5 → m1_miso reproduces 0xA5 and m0_miso stays 0 throughout.
